// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1 asynchronous serial receiver.
//
// Receives one start bit, eight data bits (LSB first) and one stop bit.
// A divider counts system clocks per bit. Each bit is sampled at its
// midpoint, counted from the start-bit falling edge.
//
// Parameters:
//   DIV_RATE  system clocks per bit (even, >= 4). The default of 260 gives
//             38400 baud from a 10 MHz clock.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   rx       in   serial line, idle high
//   rx_busy  out  high while a frame is being received
//   rx_end   out  one-cycle strobe when a frame with a valid stop bit ends
//   rx_data  out  received byte. It is valid with rx_end and held until the
//                 next frame shifts in.
//
// Configuration macro:
//   UART_RX_SYNC_EN  when defined, rx passes through a two-flop synchronizer
//                    (both flops reset to 1). This adds 2 clocks of latency.
//                    When undefined, rx must already be synchronous to clk.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DIV_RATE = 260
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_busy,
    output logic       rx_end,
    output logic [7:0] rx_data
);

    localparam int CW = $clog2(DIV_RATE);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV_RATE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV_RATE - 1);

    // bit_cnt: 0 = start bit, 1..8 = D0..D7, 9 = stop bit.
    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_STOP  = 4'd9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RX   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_end_q, rx_end_d;
    logic            rx_busy_q, rx_busy_d;
    logic            rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync1_q, sync2_q;

    // Both synchronizer flops reset to idle-high. This stops reset release
    // from looking like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;
`else
    assign rx_s = rx;
`endif

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal written here gets a default first. If a branch
        // left one unassigned, synthesis would infer a latch.
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        rx_data_d = rx_data_q;
        rx_end_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = RX;
                    div_cnt_d = HALF_M1;
                    bit_cnt_d = BIT_START;
                end
            end
            RX: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - CW'(1);
                end else begin
                    // Sample cycle: the current bit is at its midpoint.
                    div_cnt_d = FULL_M1;
                    if (bit_cnt_q == BIT_START) begin
                        // A line that is high again at mid-start is a glitch.
                        if (rx_s) state_d = IDLE;
                        else      bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == BIT_STOP) begin
                        // A low stop bit is a framing error. No strobe is
                        // raised, and the shifted bits stay in rx_data.
                        state_d  = IDLE;
                        rx_end_d = rx_s;
                    end else begin
                        rx_data_d = {rx_s, rx_data_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // rx_busy is registered from the next state. It rises on the
        // start-detect edge and falls on the stop-sample edge.
        rx_busy_d = (state_d == RX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= BIT_START;
            rx_data_q <= 8'h00;
            rx_end_q  <= 1'b0;
            rx_busy_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments. Every flop
            // then samples the values from before the edge, so there is no
            // ordering race between processes.
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            rx_data_q <= rx_data_d;
            rx_end_q  <= rx_end_d;
            rx_busy_q <= rx_busy_d;
        end
    end

    assign rx_busy = rx_busy_q;
    assign rx_end  = rx_end_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - directed self-checking bench for uart_rx at DIV_RATE = 16.
//
// The serial line is driven on falling clock edges. A monitor records, also
// on falling edges:
//   - the cycle number and data of every rx_end strobe
//   - the rise and fall cycles of rx_busy
//   - the number of cycles with rx_busy high
// Cycle N is the state after the N-th rising edge.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DIV = 16;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_busy;
    logic       rx_end;
    logic [7:0] rx_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int end_cyc_q[$];
    logic [7:0] end_data_q[$];
    int busy_rise_q[$];
    int busy_fall_q[$];
    int busy_cycles = 0;
    logic busy_prev = 1'b0;

    uart_rx #(.DIV_RATE(DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_busy (rx_busy),
        .rx_end  (rx_end),
        .rx_data (rx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_end) begin
            end_cyc_q.push_back(cyc);
            end_data_q.push_back(rx_data);
        end
        if (rx_busy) busy_cycles++;
        if (rx_busy && !busy_prev) busy_rise_q.push_back(cyc);
        if (!rx_busy && busy_prev) busy_fall_q.push_back(cyc);
        busy_prev = rx_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Call only on a falling edge while the receiver is idle.
    task automatic clear_mon();
        end_cyc_q.delete();
        end_data_q.delete();
        busy_rise_q.delete();
        busy_fall_q.delete();
        busy_cycles = 0;
    endtask

    // Drive the first ncyc cycles of a 10-bit frame.
    // Bit 0 is the start bit, bits 8:1 are data (LSB first), bit 9 is stop.
    // start_cyc is the cycle number when the start bit is first driven.
    task automatic drive_frame(input logic [9:0] bits, input int ncyc, output int start_cyc);
        logic [9:0] b;
        b = bits;
        start_cyc = 0;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            if (j == 0) start_cyc = cyc;
            rx = b[j / DIV];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    int s0, s1, t0;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("reset_busy", 32'(rx_busy), 32'd0);
        check("reset_end",  32'(rx_end),  32'd0);
        check("reset_data", 32'(rx_data), 32'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(5);

        // Single frame 0x55.
        clear_mon();
        drive_frame({1'b1, 8'h55, 1'b0}, 10 * DIV, s0);
        idle(20);
        t0 = s0 + 1 + LAT;
        check("f55_count",      32'(end_cyc_q.size()), 32'd1);
        check("f55_end_cyc",    32'(end_cyc_q[0]),     32'(t0 + 152));
        check("f55_data",       32'(end_data_q[0]),    32'h55);
        check("f55_busy_rise",  32'(busy_rise_q[0]),   32'(t0));
        check("f55_busy_fall",  32'(busy_fall_q[0]),   32'(t0 + 152));
        check("f55_busy_cycles", 32'(busy_cycles),     32'd152);

        // Back-to-back frames 0xA5 and 0x3C with no idle gap.
        clear_mon();
        drive_frame({1'b1, 8'hA5, 1'b0}, 10 * DIV, s0);
        drive_frame({1'b1, 8'h3C, 1'b0}, 10 * DIV, s1);
        idle(20);
        check("b2b_count", 32'(end_cyc_q.size()), 32'd2);
        check("b2b_gap",   32'(end_cyc_q[1] - end_cyc_q[0]), 32'd160);
        check("b2b_first_cyc", 32'(end_cyc_q[0]), 32'(s0 + 1 + LAT + 152));
        check("b2b_data0", 32'(end_data_q[0]), 32'hA5);
        check("b2b_data1", 32'(end_data_q[1]), 32'h3C);

        // Glitch: low for 4 cycles, then high.
        clear_mon();
        drive_frame(10'h3F0, 4, s0);
        idle(40);
        check("glitch_busy_cycles", 32'(busy_cycles),       32'd8);
        check("glitch_count",       32'(end_cyc_q.size()),  32'd0);
        check("glitch_data",        32'(rx_data),           32'h3C);

        // Framing error: 0xFF with a low stop bit.
        clear_mon();
        drive_frame({1'b0, 8'hFF, 1'b0}, 10 * DIV, s0);
        idle(40);
        check("ferr_count",     32'(end_cyc_q.size()), 32'd0);
        check("ferr_busy_fall", 32'(busy_fall_q[0]),   32'(s0 + 1 + LAT + 152));
        check("ferr_data",      32'(rx_data),          32'hFF);

        clear_mon();
        drive_frame({1'b1, 8'h12, 1'b0}, 10 * DIV, s0);
        idle(20);
        check("f12_count", 32'(end_cyc_q.size()), 32'd1);
        check("f12_data",  32'(end_data_q[0]),    32'h12);

        // Reset mid-frame, after D3 has been sampled.
        // Four ones shifted into 0x12 give 0xF1.
        clear_mon();
        drive_frame({1'b1, 8'hFF, 1'b0}, 80, s0);
        check("mid_data",  32'(rx_data), 32'hF1);
        check("mid_busy",  32'(rx_busy), 32'd1);
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_end",  32'(rx_end),  32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(200);
        check("rst_no_end", 32'(end_cyc_q.size()), 32'd0);

        clear_mon();
        drive_frame({1'b1, 8'h81, 1'b0}, 10 * DIV, s0);
        idle(20);
        check("f81_count",   32'(end_cyc_q.size()), 32'd1);
        check("f81_end_cyc", 32'(end_cyc_q[0]),     32'(s0 + 1 + LAT + 152));
        check("f81_data",    32'(end_data_q[0]),    32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
